onchip_sram_dp: RTL and testbench
=================================

Name: onchip_sram_dp

Overview:
- Parametrised dual-port on-chip SRAM with two independent Avalon-MM slave ports, s1 and s2.
- Adds features the single-port generation lacks:
  - configurable width and depth;
  - pipelined reads with readdatavalid, with read latency set to 1 or 2;
  - a post-reset zero-fill state machine that holds waitrequest high;
  - deterministic same-cycle collision rules.
- Sits on the system interconnect as shared scratch memory between the CPU and a DMA/accelerator master.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 12, word address width.
- DEPTH, 4096, number of words; must be ≤ 2**ADDR_W.
- READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 or 2.
- INIT_ZERO, 1, 1 = zero-fill the array after every reset; 0 = contents undefined after reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- clken  in  1  global clock enable; low freezes the block
- s1_address  in  ADDR_W  port 1 word address
- s1_byteenable  in  DATA_W/8  port 1 byte lanes
- s1_chipselect  in  1  port 1 select
- s1_read  in  1  port 1 read request
- s1_write  in  1  port 1 write request
- s1_writedata  in  DATA_W  port 1 write data
- s1_readdata  out  DATA_W  port 1 read data
- s1_readdatavalid  out  1  port 1 read data qualifier
- s1_waitrequest  out  1  port 1 stall
- s2_*  same set and widths as s1_*, for port 2

Behaviour:
- Reset (reset_n low at a clk edge):
  - state goes to CLEAR if INIT_ZERO=1, else READY;
  - readdata = 0, readdatavalid = 0, waitrequest = 1 on both ports;
  - read pipeline is flushed.
- FSM states: CLEAR, READY.
  - CLEAR writes zero to address clr_addr; clr_addr counts 0..DEPTH-1, one word per enabled cycle; takes DEPTH cycles.
  - CLEAR -> READY on the cycle after address DEPTH-1 is written.
  - READY stays READY until the next reset.
  - Reset asserted mid-CLEAR restarts the clear from address 0.
- waitrequest is high during reset, during CLEAR, and whenever clken=0; otherwise low. Ports never stall each other.
- Accept condition: chipselect & (read | write) & !waitrequest.
  - read and write both high: the write is performed and the read is ignored (no readdatavalid).
  - Address ≥ DEPTH: writes are dropped; reads return 0 with a normal readdatavalid.
- Write: byte lanes with byteenable=1 update at the accepting edge. No response cycle.
- Read:
  - READ_LATENCY=1: readdata and readdatavalid appear the cycle after accept.
  - READ_LATENCY=2: one extra output register stage.
  - readdatavalid is a single-cycle pulse per accepted read; readdata holds its last value otherwise.
- Back-to-back reads on a port: one accepted per cycle; full throughput.
- Read-during-write (either port reading an address written in the same cycle) returns the OLD data.
- Both ports write the same address in the same cycle:
  - s1 enabled lanes take s1 data;
  - lanes enabled only by s2 take s2 data;
  - implementation merges into one write and suppresses the other.
- clken=0: no accepts, memory unchanged, the read pipeline and clr_addr hold, readdatavalid is forced low while frozen. Data in flight emerges after clken returns, at the remaining latency.

Decomposition:
- Package onchip_sram_pkg:
  - state enum {CLEAR, READY};
  - localparam BE_W = DATA_W/8;
  - constants LAT_MIN=1, LAT_MAX=2;
  - elaboration checks for DATA_W%8, DEPTH, READ_LATENCY.
- Sub-module onchip_sram_dp_array:
  - pure true-dual-port, byte-enabled, read-old-data memory with registered output;
  - wraps the inference or vendor RAM.
- Top level holds the FSM, collision merge, latency pipeline and waitrequest logic.

Test Plan:
1. Zero-fill, DEPTH=16, INIT_ZERO=1: release reset_n -> waitrequest high for exactly 16 cycles. Then read all 16 addresses -> 0x00000000 each.
2. Basic write and read: s1 writes 0xDEADBEEF @5 with byteenable 0xF, then s2 writes 0x000000AA @5 with byteenable 0x1. s1 reads @5 -> 0xDEADBEAA, with readdatavalid exactly READ_LATENCY cycles after accept; repeat for latency 1 and 2.
3. Same-cycle double write @3: s1 writes 0x11223344 with byteenable 0x3, s2 writes 0xAABBCCDD with byteenable 0xE. Then read @3 -> 0xAABB3344.
4. Read-during-write @7: prior value 0x0, s1 writes 0x12345678 while s2 reads @7 -> s2 gets 0x0; the next s2 read -> 0x12345678.
5. Mid-clear reset and clken: assert reset_n low at clr_addr=8 -> clear restarts at 0, for 16 cycles. In READY, drop clken for 3 cycles with a read in flight -> readdatavalid delayed by 3 cycles, data correct.
6. Streaming: s1 issues 8 back-to-back reads of @0..7 -> 8 consecutive readdatavalid pulses with in-order data. A read @DEPTH -> 0 with readdatavalid.

Source files
------------

// File: rtl/onchip_sram_pkg.sv
// Shared types and configuration helpers for the dual-port on-chip SRAM.
package onchip_sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit cfg_ok(input int data_w, input int addr_w,
                                input int depth, input int read_latency);
    return (data_w > 0) && ((data_w % 8) == 0) &&
           (depth > 0) && (addr_w > 0) && (addr_w < 31) &&
           (depth <= (1 << addr_w)) &&
           (read_latency >= LAT_MIN) && (read_latency <= LAT_MAX);
  endfunction

endpackage

// File: rtl/onchip_sram_dp_array.sv
// True dual-port byte-enabled memory with registered read-old-data outputs.
module onchip_sram_dp_array
  import onchip_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = 12
) (
  input  logic                  clk,
  input  logic                  i_ce,
  input  logic                  i_a_we,
  input  logic                  i_a_re,
  input  logic [IDX_W-1:0]      i_a_addr,
  input  logic [DATA_W/8-1:0]   i_a_be,
  input  logic [DATA_W-1:0]     i_a_wdata,
  output logic [DATA_W-1:0]     o_a_rdata,
  input  logic                  i_b_we,
  input  logic                  i_b_re,
  input  logic [IDX_W-1:0]      i_b_addr,
  input  logic [DATA_W/8-1:0]   i_b_be,
  input  logic [DATA_W-1:0]     i_b_wdata,
  output logic [DATA_W-1:0]     o_b_rdata
);

  localparam int BE_W = be_width(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  // Non-blocking array updates give read-old-data on same-address accesses.
  always_ff @(posedge clk) begin
    if (i_ce) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_a_we && i_a_be[b]) r_mem[i_a_addr][b*8 +: 8] <= i_a_wdata[b*8 +: 8];
        if (i_b_we && i_b_be[b]) r_mem[i_b_addr][b*8 +: 8] <= i_b_wdata[b*8 +: 8];
      end
      if (i_a_re) r_a_rdata <= r_mem[i_a_addr];
      if (i_b_re) r_b_rdata <= r_mem[i_b_addr];
    end
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/onchip_sram_dp.sv
// Dual-port Avalon-MM scratch SRAM: zero-fill FSM, collision merge, read latency pipeline.
//   state | meaning
//   CLEAR | writing zero to clr_addr each enabled cycle, both ports stalled
//   READY | normal operation until the next reset
module onchip_sram_dp
  import onchip_sram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 12,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);

  localparam int                BE_W      = be_width(DATA_W);
  localparam int                IDX_W     = idx_width(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

  if (!cfg_ok(DATA_W, ADDR_W, DEPTH, READ_LATENCY)) begin : g_cfg_err
    $error("onchip_sram_dp: illegal DATA_W/ADDR_W/DEPTH/READ_LATENCY combination");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic              w_clr_we;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= (INIT_ZERO != 0) ? CLEAR : READY;
      r_clr_addr <= '0;
    end else if (clken) begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clr_we       = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we = reset_n;
        if (r_clr_addr == CLR_LAST) w_state_nxt = READY;
        else                        w_clr_addr_nxt = r_clr_addr + 1'b1;
      end
      default: ;
    endcase
  end

  logic w_wait;
  logic w_acc1, w_acc2, w_oob1, w_oob2, w_wr1, w_wr2, w_same;
  logic [1:0] w_rd;
  logic [1:0] w_oob;

  assign w_wait = !reset_n || (r_state == CLEAR) || !clken;

  assign w_acc1 = s1_chipselect & (s1_read | s1_write) & ~w_wait;
  assign w_acc2 = s2_chipselect & (s2_read | s2_write) & ~w_wait;
  assign w_oob1 = ({1'b0, s1_address} >= DEPTH_LIM);
  assign w_oob2 = ({1'b0, s2_address} >= DEPTH_LIM);
  assign w_wr1  = w_acc1 & s1_write & ~w_oob1;
  assign w_wr2  = w_acc2 & s2_write & ~w_oob2;
  assign w_rd   = {w_acc2 & s2_read & ~s2_write, w_acc1 & s1_read & ~s1_write};
  assign w_oob  = {w_oob2, w_oob1};
  assign w_same = w_wr1 & w_wr2 & (s1_address == s2_address);

  logic              w_a_we;
  logic [IDX_W-1:0]  w_a_addr;
  logic [BE_W-1:0]   w_a_be;
  logic [DATA_W-1:0] w_a_wdata;

  // Same-address double writes fold into port A; s1 owns lanes it enables.
  always_comb begin
    w_a_we    = w_wr1;
    w_a_addr  = s1_address[IDX_W-1:0];
    w_a_be    = s1_byteenable;
    w_a_wdata = s1_writedata;
    if (w_same) begin
      w_a_be = s1_byteenable | s2_byteenable;
      for (int b = 0; b < BE_W; b++) begin
        if (!s1_byteenable[b]) w_a_wdata[b*8 +: 8] = s2_writedata[b*8 +: 8];
      end
    end
    if (w_clr_we) begin
      w_a_we    = 1'b1;
      w_a_addr  = r_clr_addr[IDX_W-1:0];
      w_a_be    = '1;
      w_a_wdata = '0;
    end
  end

  logic [DATA_W-1:0] w_arr_rdata [2];

  onchip_sram_dp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk       (clk),
    .i_ce      (clken),
    .i_a_we    (w_a_we),
    .i_a_re    (w_rd[0]),
    .i_a_addr  (w_a_addr),
    .i_a_be    (w_a_be),
    .i_a_wdata (w_a_wdata),
    .o_a_rdata (w_arr_rdata[0]),
    .i_b_we    (w_wr2 & ~w_same),
    .i_b_re    (w_rd[1]),
    .i_b_addr  (s2_address[IDX_W-1:0]),
    .i_b_be    (s2_byteenable),
    .i_b_wdata (s2_writedata),
    .o_b_rdata (w_arr_rdata[1])
  );

  logic [1:0]        r_v1, r_oob1, r_seen1;
  logic [DATA_W-1:0] w_d1 [2];
  logic [1:0]        w_vout;
  logic [DATA_W-1:0] w_dout [2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v1    <= '0;
      r_oob1  <= '0;
      r_seen1 <= '0;
    end else if (clken) begin
      r_v1 <= w_rd;
      for (int p = 0; p < 2; p++) begin
        if (w_rd[p]) begin
          r_oob1[p]  <= w_oob[p];
          r_seen1[p] <= 1'b1;
        end
      end
    end
  end

  // The RAM register is not reset; mask it until the first read after reset.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_d1[p] = (r_oob1[p] || !r_seen1[p]) ? '0 : w_arr_rdata[p];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]        r_v2;
    logic [DATA_W-1:0] r_d2 [2];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_v2    <= '0;
        r_d2[0] <= '0;
        r_d2[1] <= '0;
      end else if (clken) begin
        r_v2 <= r_v1;
        for (int p = 0; p < 2; p++) begin
          if (r_v1[p]) r_d2[p] <= w_d1[p];
        end
      end
    end

    assign w_vout    = r_v2;
    assign w_dout[0] = r_d2[0];
    assign w_dout[1] = r_d2[1];
  end else begin : g_lat1
    assign w_vout    = r_v1;
    assign w_dout[0] = w_d1[0];
    assign w_dout[1] = w_d1[1];
  end

  assign s1_waitrequest   = w_wait;
  assign s2_waitrequest   = w_wait;
  assign s1_readdata      = w_dout[0];
  assign s2_readdata      = w_dout[1];
  assign s1_readdatavalid = w_vout[0] & clken & reset_n;
  assign s2_readdatavalid = w_vout[1] & clken & reset_n;

endmodule

// File: tb/tb_onchip_sram_dp.sv
// Directed scoreboard bench: latency-1 and latency-2 instances driven in lockstep.
module tb_onchip_sram_dp;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int DEP = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    int            frz;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset_n, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata;

  logic [DW-1:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
  logic          a_s1_rv, a_s2_rv, b_s1_rv, b_s2_rv;
  logic          a_s1_wq, a_s2_wq, b_s1_wq, b_s2_wq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n;
  rsp_t q_a1[$], q_a2[$], q_b1[$], q_b2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  onchip_sram_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(1), .INIT_ZERO(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_rv), .s1_waitrequest(a_s1_wq),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_rv), .s2_waitrequest(a_s2_wq)
  );

  onchip_sram_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(2), .INIT_ZERO(1)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_rv), .s1_waitrequest(b_s1_wq),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_rv), .s2_waitrequest(b_s2_wq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input rsp_t e, input logic [DW-1:0] d, input int lat);
    chk({tag, ".data"}, d, e.data);
    chk({tag, ".latency"}, cyc - e.cyc, lat + e.frz);
  endtask

  always @(negedge clk) begin
    if (a_s1_rv) begin
      chk("lat1.s1.expected_rsp", q_a1.size() > 0, 1'b1);
      if (q_a1.size() > 0) check_rsp("lat1.s1", q_a1.pop_front(), a_s1_rd, 1);
    end
    if (a_s2_rv) begin
      chk("lat1.s2.expected_rsp", q_a2.size() > 0, 1'b1);
      if (q_a2.size() > 0) check_rsp("lat1.s2", q_a2.pop_front(), a_s2_rd, 1);
    end
    if (b_s1_rv) begin
      chk("lat2.s1.expected_rsp", q_b1.size() > 0, 1'b1);
      if (q_b1.size() > 0) check_rsp("lat2.s1", q_b1.pop_front(), b_s1_rd, 2);
    end
    if (b_s2_rv) begin
      chk("lat2.s2.expected_rsp", q_b2.size() > 0, 1'b1);
      if (q_b2.size() > 0) check_rsp("lat2.s2", q_b2.pop_front(), b_s2_rd, 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
  endtask

  task automatic s1_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] be,
                       input logic [DW-1:0] exp, input int frz);
    rsp_t e;
    s1_chipselect = 1'b1; s1_read = rd; s1_write = wr;
    s1_address = a; s1_writedata = d; s1_byteenable = be;
    if (rd && !wr) begin
      e.data = exp; e.cyc = cyc; e.frz = frz;
      q_a1.push_back(e);
      q_b1.push_back(e);
    end
  endtask

  task automatic s2_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] be,
                       input logic [DW-1:0] exp, input int frz);
    rsp_t e;
    s2_chipselect = 1'b1; s2_read = rd; s2_write = wr;
    s2_address = a; s2_writedata = d; s2_byteenable = be;
    if (rd && !wr) begin
      e.data = exp; e.cyc = cyc; e.frz = frz;
      q_a2.push_back(e);
      q_b2.push_back(e);
    end
  endtask

  task automatic count_wait(output int cnt);
    cnt = 0;
    #1;
    while (a_s1_wq === 1'b1 && cnt < 64) begin
      tick();
      #1;
      cnt++;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clken = 1'b1;
    s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    repeat (3) tick();

    chk("reset.waitrequest", {a_s1_wq, a_s2_wq, b_s1_wq, b_s2_wq}, 4'hF);
    chk("reset.readdatavalid", {a_s1_rv, a_s2_rv, b_s1_rv, b_s2_rv}, 4'h0);
    chk("reset.readdata", a_s1_rd | a_s2_rd | b_s1_rd | b_s2_rd, 32'h0);

    // zero-fill length after reset release
    reset_n = 1'b1;
    count_wait(n);
    chk("clear.cycles", n, 16);
    chk("clear.other_ports_ready", {a_s2_wq, b_s1_wq, b_s2_wq}, 3'b000);

    for (int i = 0; i < DEP; i++) begin
      s1_op(1'b1, 1'b0, AW'(i), '0, '0, 32'h0, 0);
      s2_op(1'b1, 1'b0, AW'(DEP - 1 - i), '0, '0, 32'h0, 0);
      tick();
    end
    repeat (3) tick();

    // byte-lane write then merged read
    s1_op(1'b0, 1'b1, 12'd5, 32'hDEADBEEF, 4'hF, '0, 0);
    tick();
    s2_op(1'b0, 1'b1, 12'd5, 32'h000000AA, 4'h1, '0, 0);
    tick();
    s1_op(1'b1, 1'b0, 12'd5, '0, '0, 32'hDEADBEAA, 0);
    tick();

    // same-cycle double write: s1 lanes win, s2 fills the rest
    s1_op(1'b0, 1'b1, 12'd3, 32'h11223344, 4'h3, '0, 0);
    s2_op(1'b0, 1'b1, 12'd3, 32'hAABBCCDD, 4'hE, '0, 0);
    tick();
    s2_op(1'b1, 1'b0, 12'd3, '0, '0, 32'hAABB3344, 0);
    s1_op(1'b1, 1'b0, 12'd3, '0, '0, 32'hAABB3344, 0);
    tick();

    // read-during-write returns old data
    s1_op(1'b0, 1'b1, 12'd7, 32'h12345678, 4'hF, '0, 0);
    s2_op(1'b1, 1'b0, 12'd7, '0, '0, 32'h00000000, 0);
    tick();
    s2_op(1'b1, 1'b0, 12'd7, '0, '0, 32'h12345678, 0);
    tick();

    // read and write together: write wins, no response
    s1_op(1'b1, 1'b1, 12'd9, 32'h0BADF00D, 4'hF, '0, 0);
    tick();
    s1_op(1'b1, 1'b0, 12'd9, '0, '0, 32'h0BADF00D, 0);
    tick();

    // streaming reads and out-of-range access
    for (int i = 0; i < 8; i++) begin
      s2_op(1'b0, 1'b1, AW'(i), 32'hA5A50000 + i, 4'hF, '0, 0);
      tick();
    end
    s2_op(1'b0, 1'b1, 12'd16, 32'hFFFFFFFF, 4'hF, '0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      s1_op(1'b1, 1'b0, AW'(i), '0, '0, 32'hA5A50000 + i, 0);
      tick();
    end
    s1_op(1'b1, 1'b0, 12'd16, '0, '0, 32'h0, 0);
    tick();
    repeat (4) tick();

    // reset part-way through the clear restarts it
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    chk("midclear.still_clearing", a_s1_wq, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    count_wait(n);
    chk("midclear.restart_cycles", n, 16);
    s1_op(1'b1, 1'b0, 12'd5, '0, '0, 32'h0, 0);
    s2_op(1'b1, 1'b0, 12'd0, '0, '0, 32'h0, 0);
    tick();

    // clock-enable freeze with a read in flight
    s1_op(1'b0, 1'b1, 12'd2, 32'hCAFEF00D, 4'hF, '0, 0);
    tick();
    s1_op(1'b1, 1'b0, 12'd2, '0, '0, 32'hCAFEF00D, 3);
    tick();
    clken = 1'b0;
    repeat (3) begin
      s2_op(1'b0, 1'b1, 12'd2, 32'h0, 4'hF, '0, 0);
      #1;
      chk("freeze.waitrequest", {a_s2_wq, b_s2_wq}, 2'b11);
      tick();
    end
    clken = 1'b1;
    repeat (3) tick();
    s2_op(1'b1, 1'b0, 12'd2, '0, '0, 32'hCAFEF00D, 0);
    tick();
    repeat (5) tick();

    chk("drain.lat1.s1", q_a1.size(), 0);
    chk("drain.lat1.s2", q_a2.size(), 0);
    chk("drain.lat2.s1", q_b1.size(), 0);
    chk("drain.lat2.s2", q_b2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
